video_subset_axis: RTL and testbench

//  Registered AXI4-Stream successor to the combinational YUV422 subset mapper.
//  - Remaps packed video pixels of a chosen colour format into a fixed 3-slot-per-pixel output bus.
//  - Rescales component width, MSB-aligned.
//  - Buffers the stream through a 2-entry skid buffer (full throughput, registered tready).
//  - Reports per-line pixel count and frame count.

---
 rtl/video_subset_axis.sv | 168 ++++++++++++++++
 tb/tb_video_subset_axis.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/video_subset_axis.sv
// video_subset_axis: remaps packed video pixels onto a 3-slot-per-pixel
// AXI4-Stream bus, rescaling each component MSB-aligned. The stream passes
// through a 2-entry skid buffer with a registered s_axis_tready. The block
// also reports the pixel count of the last completed line and the number
// of start-of-frame beats seen.
module video_subset_axis #(
  parameter string C_COLOR_FORMAT   = "YUV422",
  parameter int    C_IN_COMP_WIDTH  = 8,
  parameter int    C_OUT_COMP_WIDTH = 12,
  parameter int    C_PPC            = 1,
  parameter string C_PAD_MODE       = "ZERO",
  parameter int    C_CNT_WIDTH      = 16,
  localparam int   NCOMP = (C_COLOR_FORMAT == "YUV422") ? 2 : 3,
  localparam int   IW    = NCOMP * C_IN_COMP_WIDTH * C_PPC,
  localparam int   OW    = 3 * C_OUT_COMP_WIDTH * C_PPC,
  localparam int   CW    = C_CNT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic          s_axis_tlast,
  input  logic          s_axis_tuser,
  output logic [OW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          m_axis_tuser,
  output logic [CW-1:0] line_len,
  output logic [CW-1:0] frame_cnt
);

  localparam int ICW     = C_IN_COMP_WIDTH;
  localparam int OCW     = C_OUT_COMP_WIDTH;
  localparam bit PAD_REP = (C_PAD_MODE == "REPLICATE");

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t        state, state_nx;
  logic [OW-1:0] mapped;
  logic [OW-1:0] out_data, skid_data;
  logic          out_last, out_user, skid_last, skid_user;
  logic          s_ready_q;
  logic          accept, out_take;
  logic          load_out_in, load_out_skid, load_skid;
  logic [CW-1:0] pix_cnt;

  // Component remap and rescale, resolved bit-by-bit at elaboration.
  // I counts bit positions down from the slot MSB; bits below the input
  // width are padded with zeros or with the input MSBs repeated cyclically.
  for (genvar p = 0; p < C_PPC; p++) begin : g_pix
    for (genvar k = 0; k < 3; k++) begin : g_slot
      localparam int COMP = (NCOMP == 2) ? k - 1 : k;
      for (genvar b = 0; b < OCW; b++) begin : g_bit
        localparam int I    = OCW - 1 - b;
        localparam int OBIT = (3 * p + k) * OCW + b;
        if (COMP < 0) begin : g_zero
          assign mapped[OBIT] = 1'b0;
        end else if (I < ICW) begin : g_copy
          assign mapped[OBIT] = s_axis_tdata[(NCOMP * p + COMP) * ICW + ICW - 1 - I];
        end else if (PAD_REP) begin : g_rep
          assign mapped[OBIT] = s_axis_tdata[(NCOMP * p + COMP) * ICW + ICW - 1 - (I % ICW)];
        end else begin : g_pad
          assign mapped[OBIT] = 1'b0;
        end
      end
    end
  end

  assign accept   = s_axis_tvalid & s_ready_q;
  assign out_take = m_axis_tvalid & m_axis_tready;

  // Skid FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nx;
  end

  // Skid FSM next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_EMPTY: if (accept) state_nx = ST_ONE;
      ST_ONE: begin
        if (accept && !out_take)      state_nx = ST_FULL;
        else if (out_take && !accept) state_nx = ST_EMPTY;
      end
      ST_FULL:  if (out_take) state_nx = ST_ONE;
      default:  state_nx = ST_EMPTY;
    endcase
  end

  // Skid FSM outputs: register load strobes and output valid
  always_comb begin
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    m_axis_tvalid = (state != ST_EMPTY);
    unique case (state)
      ST_EMPTY: load_out_in = accept;
      ST_ONE: begin
        load_out_in = accept & out_take;
        load_skid   = accept & ~out_take;
      end
      ST_FULL:  load_out_skid = out_take;
      default: ;
    endcase
  end

  // Input ready is registered from the next state so m_axis_tready never
  // reaches s_axis_tready combinationally; held low throughout reset.
  always_ff @(posedge clk) begin
    if (rst) s_ready_q <= 1'b0;
    else     s_ready_q <= (state_nx != ST_FULL);
  end

  // Output and skid data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
      skid_user <= 1'b0;
    end else begin
      if (load_out_in) begin
        out_data <= mapped;
        out_last <= s_axis_tlast;
        out_user <= s_axis_tuser;
      end else if (load_out_skid) begin
        out_data <= skid_data;
        out_last <= skid_last;
        out_user <= skid_user;
      end
      if (load_skid) begin
        skid_data <= mapped;
        skid_last <= s_axis_tlast;
        skid_user <= s_axis_tuser;
      end
    end
  end

  // Pixel, line-length and frame counters, updated on accepted input beats.
  // A start-of-frame beat clears the running count before adding its pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt   <= '0;
      line_len  <= '0;
      frame_cnt <= '0;
    end else if (accept) begin
      if (s_axis_tuser) frame_cnt <= frame_cnt + 1'b1;
      if (s_axis_tlast) begin
        line_len <= (s_axis_tuser ? '0 : pix_cnt) + CW'(C_PPC);
        pix_cnt  <= '0;
      end else begin
        pix_cnt  <= (s_axis_tuser ? '0 : pix_cnt) + CW'(C_PPC);
      end
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tdata  = out_data;
  assign m_axis_tlast  = out_last;
  assign m_axis_tuser  = out_user;

endmodule

// File: tb/tb_video_subset_axis.sv
// Directed bench for video_subset_axis across three configurations:
// dut0 YUV422 8->12 ZERO PPC=1, dut1 RGB 8->12 REPLICATE PPC=2,
// dut2 YUV444 16->8 PPC=1.
module tb_video_subset_axis;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [15:0] s0_data;  logic s0_valid, s0_ready, s0_last, s0_user;
  logic [35:0] m0_data;  logic m0_valid, m0_ready, m0_last, m0_user;
  logic [15:0] ll0, fc0;

  logic [47:0] s1_data;  logic s1_valid, s1_ready, s1_last, s1_user;
  logic [71:0] m1_data;  logic m1_valid, m1_ready, m1_last, m1_user;
  logic [15:0] ll1, fc1;

  logic [47:0] s2_data;  logic s2_valid, s2_ready, s2_last, s2_user;
  logic [23:0] m2_data;  logic m2_valid, m2_ready, m2_last, m2_user;
  logic [15:0] ll2, fc2;

  int n_cmp = 0;
  int n_bad = 0;

  video_subset_axis #(.C_COLOR_FORMAT("YUV422"), .C_IN_COMP_WIDTH(8), .C_OUT_COMP_WIDTH(12),
                      .C_PPC(1), .C_PAD_MODE("ZERO"), .C_CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s0_data), .s_axis_tvalid(s0_valid), .s_axis_tready(s0_ready),
    .s_axis_tlast(s0_last), .s_axis_tuser(s0_user),
    .m_axis_tdata(m0_data), .m_axis_tvalid(m0_valid), .m_axis_tready(m0_ready),
    .m_axis_tlast(m0_last), .m_axis_tuser(m0_user),
    .line_len(ll0), .frame_cnt(fc0));

  video_subset_axis #(.C_COLOR_FORMAT("RGB"), .C_IN_COMP_WIDTH(8), .C_OUT_COMP_WIDTH(12),
                      .C_PPC(2), .C_PAD_MODE("REPLICATE"), .C_CNT_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s1_data), .s_axis_tvalid(s1_valid), .s_axis_tready(s1_ready),
    .s_axis_tlast(s1_last), .s_axis_tuser(s1_user),
    .m_axis_tdata(m1_data), .m_axis_tvalid(m1_valid), .m_axis_tready(m1_ready),
    .m_axis_tlast(m1_last), .m_axis_tuser(m1_user),
    .line_len(ll1), .frame_cnt(fc1));

  video_subset_axis #(.C_COLOR_FORMAT("YUV444"), .C_IN_COMP_WIDTH(16), .C_OUT_COMP_WIDTH(8),
                      .C_PPC(1), .C_PAD_MODE("ZERO"), .C_CNT_WIDTH(16)) dut2 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s2_data), .s_axis_tvalid(s2_valid), .s_axis_tready(s2_ready),
    .s_axis_tlast(s2_last), .s_axis_tuser(s2_user),
    .m_axis_tdata(m2_data), .m_axis_tvalid(m2_valid), .m_axis_tready(m2_ready),
    .m_axis_tlast(m2_last), .m_axis_tuser(m2_user),
    .line_len(ll2), .frame_cnt(fc2));

  // Reference YUV422 8->12 zero-pad mapping: {C,4'0, Y,4'0, 12'0}
  function automatic logic [35:0] exp0(input logic [15:0] d);
    return {d[15:8], 4'h0, d[7:0], 4'h0, 12'h000};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    s0_valid = 0; s0_data = '0; s0_last = 0; s0_user = 0; m0_ready = 0;
    s1_valid = 0; s1_data = '0; s1_last = 0; s1_user = 0; m1_ready = 0;
    s2_valid = 0; s2_data = '0; s2_last = 0; s2_user = 0; m2_ready = 0;
    repeat (3) tick();
    n_cmp++; if (m0_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid got %b want 0", m0_valid); end
    n_cmp++; if (s0_ready !== 1'b0) begin n_bad++; $display("FAIL rst_s_ready got %b want 0", s0_ready); end
    n_cmp++; if (m0_data !== 36'h0) begin n_bad++; $display("FAIL rst_m_data got %h want 0", m0_data); end
    n_cmp++; if (ll0 !== 16'h0 || fc0 !== 16'h0) begin n_bad++; $display("FAIL rst_counters got %0d/%0d want 0/0", ll0, fc0); end
    rst = 1'b0;
    tick();
    n_cmp++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1 || s2_ready !== 1'b1) begin
      n_bad++; $display("FAIL post_rst_ready got %b%b%b want 111", s0_ready, s1_ready, s2_ready); end
    n_cmp++; if (m0_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_m_valid got %b want 0", m0_valid); end
  endtask

  task automatic test_yuv422_map;
    m0_ready = 1; s0_valid = 1; s0_data = 16'hA53C; s0_last = 1; s0_user = 1;
    tick();
    s0_valid = 0; s0_last = 0; s0_user = 0;
    n_cmp++; if (m0_valid !== 1'b1) begin n_bad++; $display("FAIL yuv_valid got %b want 1", m0_valid); end
    n_cmp++; if (m0_data !== 36'hA50_3C0_000) begin n_bad++; $display("FAIL yuv_data got %h want a503c0000", m0_data); end
    n_cmp++; if (m0_last !== 1'b1 || m0_user !== 1'b1) begin n_bad++; $display("FAIL yuv_sideband got %b%b want 11", m0_last, m0_user); end
    n_cmp++; if (ll0 !== 16'd1 || fc0 !== 16'd1) begin n_bad++; $display("FAIL yuv_counters got %0d/%0d want 1/1", ll0, fc0); end
    tick();
    n_cmp++; if (m0_valid !== 1'b0) begin n_bad++; $display("FAIL yuv_drain got %b want 0", m0_valid); end
  endtask

  task automatic test_backpressure;
    m0_ready = 1; s0_valid = 1; s0_data = 16'h0101;
    tick();
    s0_data = 16'h0202;
    tick();
    s0_data = 16'h0303; m0_ready = 0;
    tick();
    s0_data = 16'h0404;
    n_cmp++; if (s0_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_fall got %b want 0", s0_ready); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (s0_ready !== 1'b0 || m0_valid !== 1'b1 || m0_data !== exp0(16'h0202)) begin
        n_bad++; $display("FAIL bp_hold got ready=%b valid=%b data=%h want 0 1 %h", s0_ready, m0_valid, m0_data, exp0(16'h0202)); end
    end
    m0_ready = 1;
    tick();
    n_cmp++; if (m0_data !== exp0(16'h0303) || s0_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_skid_out got data=%h ready=%b want %h 1", m0_data, s0_ready, exp0(16'h0303)); end
    tick();
    s0_valid = 0;
    n_cmp++; if (m0_data !== exp0(16'h0404)) begin n_bad++; $display("FAIL bp_next got %h want %h", m0_data, exp0(16'h0404)); end
    tick();
    n_cmp++; if (m0_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b want 0", m0_valid); end
  endtask

  task automatic test_random;
    logic [37:0] q[$];
    logic [37:0] e;
    bit drv_done;
    int n_acc;
    drv_done = 0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          int w;
          s0_valid = 1;
          s0_data = 16'($urandom);
          s0_last = 1'($urandom_range(0, 1));
          s0_user = ($urandom_range(0, 7) == 0);
          w = 0;
          do begin @(negedge clk); w++; end while (!s0_ready && w < 50);
          if (!s0_ready) begin n_cmp++; n_bad++; $display("FAIL rnd_in_timeout beat %0d", i); end
          tick();
        end
        s0_valid = 0;
        drv_done = 1;
      end
      begin
        while (!drv_done) begin
          tick();
          m0_ready = ($urandom_range(0, 3) != 0);
        end
        m0_ready = 1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!(drv_done && q.size() == 0 && !m0_valid) && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          if (m0_valid && m0_ready) begin
            if (q.size() == 0) begin
              n_cmp++; n_bad++; $display("FAIL rnd_extra got %h want none", m0_data);
            end else begin
              e = q.pop_front();
              n_cmp++; if ({m0_user, m0_last, m0_data} !== e) begin
                n_bad++; $display("FAIL rnd_beat got %h want %h", {m0_user, m0_last, m0_data}, e); end
            end
          end
          if (s0_valid && s0_ready) begin
            q.push_back({s0_user, s0_last, exp0(s0_data)});
            n_acc++;
          end
        end
        if (cyc >= 3000) begin n_cmp++; n_bad++; $display("FAIL rnd_drain_timeout left %0d", q.size()); end
      end
    join
    n_cmp++; if (n_acc !== 100) begin n_bad++; $display("FAIL rnd_count got %0d want 100", n_acc); end
  endtask

  task automatic test_rgb_replicate;
    m1_ready = 1; s1_valid = 1; s1_data = 48'h12_34_56_FF_80_01; s1_last = 0; s1_user = 0;
    tick();
    s1_valid = 0;
    n_cmp++; if (m1_valid !== 1'b1 || m1_data !== 72'h121_343_565_FFF_808_010) begin
      n_bad++; $display("FAIL rgb_map got valid=%b data=%h want 1 121343565fff808010", m1_valid, m1_data); end
    tick();
  endtask

  task automatic send1(input logic [47:0] d, input logic last, input logic user);
    int w;
    s1_valid = 1; s1_data = d; s1_last = last; s1_user = user;
    w = 0;
    do begin @(negedge clk); w++; end while (!s1_ready && w < 50);
    if (!s1_ready) begin n_cmp++; n_bad++; $display("FAIL line_in_timeout"); end
    tick();
    s1_valid = 0; s1_last = 0; s1_user = 0;
  endtask

  task automatic test_line_frame;
    m1_ready = 1;
    for (int i = 0; i < 960; i++) send1(48'(i), (i == 959), (i == 0));
    tick();
    n_cmp++; if (ll1 !== 16'd1920) begin n_bad++; $display("FAIL line_len_1920 got %0d want 1920", ll1); end
    n_cmp++; if (fc1 !== 16'd1) begin n_bad++; $display("FAIL frame_cnt_1 got %0d want 1", fc1); end
    send1(48'h1, 1'b1, 1'b1);
    send1(48'h2, 1'b1, 1'b1);
    n_cmp++; if (fc1 !== 16'd3) begin n_bad++; $display("FAIL frame_cnt_3 got %0d want 3", fc1); end
    n_cmp++; if (ll1 !== 16'd2) begin n_bad++; $display("FAIL line_len_sof_last got %0d want 2", ll1); end
    for (int i = 0; i < 3; i++) send1(48'h3, (i == 2), 1'b0);
    n_cmp++; if (ll1 !== 16'd6) begin n_bad++; $display("FAIL line_len_6 got %0d want 6", ll1); end
    tick();
  endtask

  task automatic test_truncate;
    m2_ready = 1; s2_valid = 1; s2_data = {16'hABCD, 16'hABCD, 16'hABCD};
    tick();
    s2_data = {16'h1234, 16'hABCD, 16'hFF00};
    n_cmp++; if (m2_data !== 24'hABABAB) begin n_bad++; $display("FAIL trunc_same got %h want ababab", m2_data); end
    tick();
    s2_valid = 0;
    n_cmp++; if (m2_data !== 24'h12ABFF) begin n_bad++; $display("FAIL trunc_slots got %h want 12abff", m2_data); end
    tick();
  endtask

  task automatic test_reset_full;
    m0_ready = 0; s0_valid = 1; s0_data = 16'h1111; s0_last = 1; s0_user = 1;
    tick();
    s0_data = 16'h2222; s0_last = 0; s0_user = 0;
    tick();
    s0_valid = 0;
    n_cmp++; if (s0_ready !== 1'b0 || m0_valid !== 1'b1) begin
      n_bad++; $display("FAIL full_setup got ready=%b valid=%b want 0 1", s0_ready, m0_valid); end
    rst = 1;
    tick();
    n_cmp++; if (m0_valid !== 1'b0 || s0_ready !== 1'b0) begin
      n_bad++; $display("FAIL full_rst got valid=%b ready=%b want 0 0", m0_valid, s0_ready); end
    n_cmp++; if (ll0 !== 16'h0 || fc0 !== 16'h0 || m0_data !== 36'h0) begin
      n_bad++; $display("FAIL full_rst_state got ll=%0d fc=%0d data=%h want 0 0 0", ll0, fc0, m0_data); end
    rst = 0;
    m0_ready = 1;
    tick();
    n_cmp++; if (s0_ready !== 1'b1 || m0_valid !== 1'b0) begin
      n_bad++; $display("FAIL full_post_rst got ready=%b valid=%b want 1 0", s0_ready, m0_valid); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_yuv422_map();
    test_backpressure();
    test_random();
    test_rgb_replicate();
    test_line_frame();
    test_truncate();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
